// File: rtl/temp_ram_writer.sv
// rtl/temp_ram_writer.sv - writes a 16-bit temperature sample into the i2c_slave RAM as two bytes (optional readback check: RD_VERIFY_EN)
module temp_ram_writer #(
  parameter logic [7:0] BASE_ADDR = 8'h55,
  parameter int         PAD_LSB   = 3
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        ram_ce,
  output logic        ram_wre,
  output logic [13:0] ram_address,
  output logic [7:0]  ram_di,
  input  logic [7:0]  ram_do,
  output logic        done,
  output logic [15:0] wr_count,
  output logic        err
);

  localparam int         PAD_MSB = 14 - 8 - PAD_LSB;
  localparam logic [7:0] ADDR_LO = BASE_ADDR + 8'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_SET_HI, S_STB_HI, S_SET_LO, S_STB_LO, S_DONE,
    S_RD_HI, S_CAP_HI, S_RD_LO, S_CAP_LO
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  di_q, di_d;
  logic        ce_q, ce_d;
  logic        wre_q, wre_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
`ifdef RD_VERIFY_EN
  logic [7:0]  hi_q, hi_d;
  logic        err_q, err_d;
`endif

  // Next state and sample latch; the sample is captured only on the accepting edge
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SET_HI;
          data_d  = in_data;
        end
      end
      S_SET_HI: state_d = S_STB_HI;
      S_STB_HI: state_d = S_SET_LO;
      S_SET_LO: state_d = S_STB_LO;
`ifdef RD_VERIFY_EN
      S_STB_LO: state_d = S_RD_HI;
      S_RD_HI:  state_d = S_CAP_HI;
      S_CAP_HI: state_d = S_RD_LO;
      S_RD_LO:  state_d = S_CAP_LO;
      S_CAP_LO: state_d = S_DONE;
`else
      S_STB_LO: state_d = S_DONE;
`endif
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Registered pin values decoded from the state being entered, so pins track the state cycle-exactly
  always_comb begin
    ce_d   = 1'b0;
    wre_d  = 1'b0;
    done_d = 1'b0;
    addr_d = addr_q;
    di_d   = di_q;
    cnt_d  = cnt_q;
    case (state_d)
      S_SET_HI, S_STB_HI: begin
        addr_d = BASE_ADDR;
        di_d   = data_d[15:8];
        wre_d  = 1'b1;
        ce_d   = (state_d == S_STB_HI);
      end
      S_SET_LO, S_STB_LO: begin
        addr_d = ADDR_LO;
        di_d   = data_d[7:0];
        wre_d  = 1'b1;
        ce_d   = (state_d == S_STB_LO);
      end
      S_RD_HI: begin
        addr_d = BASE_ADDR;
        ce_d   = 1'b1;
      end
      S_RD_LO: begin
        addr_d = ADDR_LO;
        ce_d   = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
        cnt_d  = cnt_q + 16'd1;
      end
      default: ;
    endcase
  end

`ifdef RD_VERIFY_EN
  // Readback capture; the low byte is compared straight off ram_do as CAP_LO closes
  always_comb begin
    hi_d  = hi_q;
    err_d = err_q;
    if (state_q == S_CAP_HI) hi_d = ram_do;
    if (state_q == S_CAP_LO && {hi_q, ram_do} != data_q) err_d = 1'b1;
  end

  // Readback registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= 8'h00;
      err_q <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_ram_do;
  assign unused_ram_do = ^ram_do;
  assign err = 1'b0;
`endif

  // State, sample and output registers
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= 16'h0000;
      addr_q  <= 8'h00;
      di_q    <= 8'h00;
      ce_q    <= 1'b0;
      wre_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      ce_q    <= ce_d;
      wre_q   <= wre_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign ram_ce      = ce_q;
  assign ram_wre     = wre_q;
  assign ram_address = {{PAD_MSB{1'b0}}, addr_q, {PAD_LSB{1'b0}}};
  assign ram_di      = di_q;
  assign done        = done_q;
  assign wr_count    = cnt_q;

endmodule
